pipeline_hazard_controller: RTL and testbench

- Sequences the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Drives per-stage write enables and bubble-insert flushes for three cases: load-use hazards, branch/jump redirects and RAM handshake stalls.
- Watches RAM wait time with a watchdog and raises a sticky error on timeout.
- Sits beside the datapath top, and its outputs connect directly to each pipeline register's wren and flush inputs.

---
 rtl/pipeline_hazard_controller_pkg.sv | 12 +
 rtl/pipeline_hazard_controller_if.sv | 55 +++++
 rtl/pipeline_hazard_controller_mem_wait_fsm.sv | 80 ++++++++
 rtl/pipeline_hazard_controller.sv | 99 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared FSM state encoding and register constants for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller bus between the datapath (master) and the controller (slave).
// Optional HAZARD_PERF_COUNTERS_EN adds three 32-bit performance counters.
interface pipeline_hazard_controller_if;
    logic [4:0] id_rs1_address;
    logic [4:0] id_rs2_address;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd_address;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_wren;
    logic       if_id_wren;
    logic       id_ex_wren;
    logic       ex_mem_wren;
    logic       mem_wb_wren;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_stall;
    logic       mem_timeout;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_mem_stall_cycles;
    logic [31:0] perf_load_use_bubbles;
    logic [31:0] perf_redirects;

    modport master (
        output id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
               ex_rd_address, ex_mem_read, ex_redirect, mem_req, mem_ready,
        input  pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
               if_id_flush, id_ex_flush, mem_stall, mem_timeout,
               perf_mem_stall_cycles, perf_load_use_bubbles, perf_redirects
    );
    modport slave (
        input  id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
               ex_rd_address, ex_mem_read, ex_redirect, mem_req, mem_ready,
        output pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
               if_id_flush, id_ex_flush, mem_stall, mem_timeout,
               perf_mem_stall_cycles, perf_load_use_bubbles, perf_redirects
    );
`else
    modport master (
        output id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
               ex_rd_address, ex_mem_read, ex_redirect, mem_req, mem_ready,
        input  pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
               if_id_flush, id_ex_flush, mem_stall, mem_timeout
    );
    modport slave (
        input  id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
               ex_rd_address, ex_mem_read, ex_redirect, mem_req, mem_ready,
        output pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
               if_id_flush, id_ex_flush, mem_stall, mem_timeout
    );
`endif
endinterface

// File: rtl/pipeline_hazard_controller_mem_wait_fsm.sv
// RAM handshake FSM: tracks wait cycles, raises the freeze condition and a sticky watchdog error.
module hazard_mem_wait_fsm
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_CNT_W  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_mem_req,
    input  logic i_mem_ready,
    output logic o_stall,
    output logic o_timeout
);

    localparam logic [WAIT_CNT_W-1:0] CNT_ONE     = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    hz_state_e               r_state;
    hz_state_e               w_state_next;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_next;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_inc;
    logic                    r_timeout;
    logic                    w_timeout_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_timeout  <= w_timeout_next;
        end
    end

    // Saturating increment so the counter can never wrap back below the threshold.
    assign w_wait_cnt_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_ONE;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_timeout_next  = r_timeout;
        o_stall         = 1'b0;
        case (r_state)
            RUN: begin
                o_stall = i_mem_req && !i_mem_ready;
                if (i_mem_req && !i_mem_ready) begin
                    w_state_next    = MEM_WAIT;
                    w_wait_cnt_next = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                // mem_req is ignored here: a dropped request still waits for ready.
                o_stall = !i_mem_ready;
                if (i_mem_ready) begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end else begin
                    w_wait_cnt_next = w_wait_cnt_inc;
                    if (w_wait_cnt_inc >= TIMEOUT_VAL) begin
                        w_state_next   = ERROR;
                        w_timeout_next = 1'b1;
                    end
                end
            end
            ERROR: begin
                o_stall = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: per-stage write enables and flushes for stalls, redirects and load-use.
// Optional HAZARD_PERF_COUNTERS_EN adds stall/bubble/redirect performance counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    pipeline_hazard_controller_if.slave   hz
);

    logic w_stall;
    logic w_timeout;
    logic w_load_use;
    logic w_redirect_case;
    logic w_load_use_case;

    hazard_mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .WAIT_CNT_W  (WAIT_CNT_W)
    ) u_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_mem_req   (hz.mem_req),
        .i_mem_ready (hz.mem_ready),
        .o_stall     (w_stall),
        .o_timeout   (w_timeout)
    );

    assign w_load_use = hz.ex_mem_read && (hz.ex_rd_address != REG_ZERO) &&
                        ((hz.id_uses_rs1 && (hz.id_rs1_address == hz.ex_rd_address)) ||
                         (hz.id_uses_rs2 && (hz.id_rs2_address == hz.ex_rd_address)));

    assign w_redirect_case = reset_n && !w_stall && hz.ex_redirect;
    assign w_load_use_case = reset_n && !w_stall && !hz.ex_redirect && w_load_use;

    always_comb begin
        hz.pc_wren     = 1'b0;
        hz.if_id_wren  = 1'b0;
        hz.id_ex_wren  = 1'b0;
        hz.ex_mem_wren = 1'b0;
        hz.mem_wb_wren = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        // A frozen EX defers redirect and load-use; they re-evaluate on release.
        if (!reset_n || w_stall) begin
            hz.pc_wren = 1'b0;
        end else if (hz.ex_redirect) begin
            hz.pc_wren     = 1'b1;
            hz.if_id_wren  = 1'b1;
            hz.id_ex_wren  = 1'b1;
            hz.ex_mem_wren = 1'b1;
            hz.mem_wb_wren = 1'b1;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            hz.id_ex_flush = 1'b1;
            hz.ex_mem_wren = 1'b1;
            hz.mem_wb_wren = 1'b1;
        end else begin
            hz.pc_wren     = 1'b1;
            hz.if_id_wren  = 1'b1;
            hz.id_ex_wren  = 1'b1;
            hz.ex_mem_wren = 1'b1;
            hz.mem_wb_wren = 1'b1;
        end
    end

    assign hz.mem_stall   = reset_n && w_stall;
    assign hz.mem_timeout = w_timeout;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_stall    <= '0;
            r_perf_bubble   <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (w_stall)         r_perf_stall    <= r_perf_stall + 32'd1;
            if (w_load_use_case) r_perf_bubble   <= r_perf_bubble + 32'd1;
            if (w_redirect_case) r_perf_redirect <= r_perf_redirect + 32'd1;
        end
    end

    assign hz.perf_mem_stall_cycles = r_perf_stall;
    assign hz.perf_load_use_bubbles = r_perf_bubble;
    assign hz.perf_redirects        = r_perf_redirect;
`else
    logic w_unused_cases;
    assign w_unused_cases = w_redirect_case ^ w_load_use_case;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with MEM_TIMEOUT=4.
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb wren, if_id_flush, id_ex_flush, mem_stall
    localparam logic [7:0] OUT_ZERO  = 8'b00000_00_0;
    localparam logic [7:0] OUT_RUN   = 8'b11111_00_0;
    localparam logic [7:0] OUT_STALL = 8'b00000_00_1;
    localparam logic [7:0] OUT_REDIR = 8'b11111_11_0;
    localparam logic [7:0] OUT_LU    = 8'b00011_01_0;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    pipeline_hazard_controller_if hz ();

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (4),
        .WAIT_CNT_W  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {hz.pc_wren, hz.if_id_wren, hz.id_ex_wren, hz.ex_mem_wren, hz.mem_wb_wren,
                hz.if_id_flush, hz.id_ex_flush, hz.mem_stall};
    endfunction

    task automatic chk_out(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = outs();
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("[TB] %s outputs=%b", tag, obs);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs1_address = 5'd0;
        hz.id_rs2_address = 5'd0;
        hz.id_uses_rs1    = 1'b0;
        hz.id_uses_rs2    = 1'b0;
        hz.ex_rd_address  = 5'd0;
        hz.ex_mem_read    = 1'b0;
        hz.ex_redirect    = 1'b0;
        hz.mem_req        = 1'b0;
        hz.mem_ready      = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        idle_inputs();
        #2;
        chk_out("reset_outputs", OUT_ZERO);
        chk_bit("reset_timeout", hz.mem_timeout, 1'b0);
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;
        chk_out("idle_run", OUT_RUN);

        // Load-use on rs1 for one cycle, then the bubble has left EX
        cyc();
        hz.ex_mem_read = 1'b1; hz.ex_rd_address = 5'd5;
        hz.id_rs1_address = 5'd5; hz.id_uses_rs1 = 1'b1;
        #1 chk_out("load_use_rs1", OUT_LU);
        cyc();
        hz.ex_mem_read = 1'b0;
        #1 chk_out("load_use_released", OUT_RUN);

        // x0 destination never hazards
        cyc();
        hz.ex_mem_read = 1'b1; hz.ex_rd_address = 5'd0; hz.id_rs1_address = 5'd0;
        #1 chk_out("load_use_x0", OUT_RUN);

        // rs2 match only counts when rs2 is actually read
        cyc();
        hz.ex_rd_address = 5'd9; hz.id_rs1_address = 5'd3;
        hz.id_rs2_address = 5'd9; hz.id_uses_rs2 = 1'b0;
        #1 chk_out("rs2_unused", OUT_RUN);
        hz.id_uses_rs2 = 1'b1;
        #1 chk_out("load_use_rs2", OUT_LU);

        // Redirect overrides load-use
        cyc();
        hz.ex_redirect = 1'b1;
        #1 chk_out("redirect_over_lu", OUT_REDIR);
        cyc();
        idle_inputs();

        // Zero-wait access does not stall
        hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        #1 chk_out("zero_wait", OUT_RUN);

        // Three stall cycles, released on the ready cycle
        cyc();
        hz.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk_out($sformatf("wait3_stall%0d", i), OUT_STALL);
            cyc();
        end
        hz.mem_ready = 1'b1;
        #1 chk_out("wait3_ready", OUT_RUN);
        chk_bit("wait3_no_timeout", hz.mem_timeout, 1'b0);
        cyc();
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        #1 chk_out("wait3_after", OUT_RUN);
        chk_bit("wait3_state_run", (dut.u_fsm.r_state == RUN), 1'b1);

        // Redirect held during a 2-cycle wait is deferred to the release cycle
        cyc();
        hz.mem_req = 1'b1; hz.ex_redirect = 1'b1;
        #1 chk_out("redir_wait0", OUT_STALL);
        cyc();
        #1 chk_out("redir_wait1", OUT_STALL);
        cyc();
        hz.mem_ready = 1'b1;
        #1 chk_out("redir_release", OUT_REDIR);
        cyc();
        idle_inputs();
        #1 chk_out("redir_after", OUT_RUN);

        // Dropping mem_req mid-wait keeps the freeze until ready
        cyc();
        hz.mem_req = 1'b1;
        #1 chk_out("drop_req_wait0", OUT_STALL);
        cyc();
        hz.mem_req = 1'b0;
        #1 chk_out("drop_req_still_stalled", OUT_STALL);
        cyc();
        hz.mem_ready = 1'b1;
        #1 chk_out("drop_req_ready", OUT_RUN);
        cyc();
        idle_inputs();

        // Watchdog: 4 stalled cycles, then ERROR with sticky timeout
        hz.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk_out($sformatf("to_stall%0d", i), OUT_STALL);
            chk_bit($sformatf("to_pending%0d", i), hz.mem_timeout, 1'b0);
            cyc();
        end
        #1 chk_out("to_error_stall", OUT_STALL);
        chk_bit("to_raised", hz.mem_timeout, 1'b1);
        hz.mem_ready = 1'b1; hz.ex_redirect = 1'b1;
        cyc();
        #1 chk_out("to_error_absorbing", OUT_STALL);
        chk_bit("to_sticky", hz.mem_timeout, 1'b1);
        cyc();
        chk_bit("to_sticky2", hz.mem_timeout, 1'b1);

        // Reset clears ERROR asynchronously
        #2 reset_n = 1'b0;
        #1 chk_out("err_reset_outputs", OUT_ZERO);
        chk_bit("err_reset_timeout", hz.mem_timeout, 1'b0);
        idle_inputs();
        cyc();
        reset_n = 1'b1;
        #1 chk_out("err_reset_release", OUT_RUN);

        // Async reset in the middle of MEM_WAIT with a pending redirect
        cyc();
        hz.mem_req = 1'b1; hz.ex_redirect = 1'b1;
        cyc();
        #1 chk_out("midwait_stall", OUT_STALL);
        chk_bit("midwait_in_wait", (dut.u_fsm.r_state == MEM_WAIT), 1'b1);
        #1 reset_n = 1'b0;
        #1 chk_out("midwait_reset_outputs", OUT_ZERO);
        chk_bit("midwait_reset_state", (dut.u_fsm.r_state == RUN), 1'b1);
        idle_inputs();
        cyc();
        reset_n = 1'b1;
        #1 chk_out("midwait_release", OUT_RUN);
        chk_bit("midwait_cnt_zero", (dut.u_fsm.r_wait_cnt == 16'd0), 1'b1);
        cyc();
        #1 chk_out("midwait_no_pending_flush", OUT_RUN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
